// File: rtl/identity_checker.sv
// rtl/identity_checker.sv - sweeps all 16 {a,x,y,z} vectors through an identity block and scores lhs vs rhs
// Each vector is held SETTLE cycles in DRIVE, then compared for one cycle in CHECK.
module identity_checker #(
  parameter int SETTLE = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic [3:0] vec,
  input  logic [2:0] lhs,
  input  logic [2:0] rhs,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [4:0] err_cnt,
  output logic [2:0] err_mask,
  output logic [3:0] fail_vec,
  output logic       fail_valid
);

  typedef enum logic [1:0] {IDLE, DRIVE, CHECK, DONE} state_t;

  localparam logic [3:0] RELOAD = 4'(SETTLE - 1);

  state_t     state, state_n;
  logic [3:0] idx, idx_n;
  logic [3:0] cnt, cnt_n;
  logic [4:0] err_cnt_n;
  logic [2:0] err_mask_n;
  logic [3:0] fail_vec_n;
  logic       fail_valid_n;
  logic       busy_n, done_n, pass_n;
  logic [2:0] m;
  logic       launch;

  assign m      = lhs ^ rhs;
  assign launch = ((state == IDLE) || (state == DONE)) && start;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      idx        <= 4'd0;
      cnt        <= 4'd0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      err_cnt    <= 5'd0;
      err_mask   <= 3'd0;
      fail_vec   <= 4'd0;
      fail_valid <= 1'b0;
    end else begin
      state      <= state_n;
      idx        <= idx_n;
      cnt        <= cnt_n;
      busy       <= busy_n;
      done       <= done_n;
      pass       <= pass_n;
      err_cnt    <= err_cnt_n;
      err_mask   <= err_mask_n;
      fail_vec   <= fail_vec_n;
      fail_valid <= fail_valid_n;
    end
  end

  always_comb begin
    state_n = state;
    idx_n   = idx;
    cnt_n   = cnt;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_n = DRIVE;
          idx_n   = 4'd0;
          cnt_n   = RELOAD;
        end
      end
      DRIVE: begin
        if (cnt == 4'd0) state_n = CHECK;
        else             cnt_n   = cnt - 4'd1;
      end
      CHECK: begin
        // idx 15 is terminal; the counter never wraps back to 0 mid-run
        if (idx == 4'd15) begin
          state_n = DONE;
        end else begin
          state_n = DRIVE;
          idx_n   = idx + 4'd1;
          cnt_n   = RELOAD;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    err_cnt_n    = err_cnt;
    err_mask_n   = err_mask;
    fail_vec_n   = fail_vec;
    fail_valid_n = fail_valid;
    vec          = ((state == DRIVE) || (state == CHECK)) ? idx : 4'd0;
    if (launch) begin
      err_cnt_n    = 5'd0;
      err_mask_n   = 3'd0;
      fail_vec_n   = 4'd0;
      fail_valid_n = 1'b0;
    end else if (state == CHECK) begin
      err_mask_n = err_mask | m;
      if (m != 3'd0) begin
        if (err_cnt != 5'd16) err_cnt_n = err_cnt + 5'd1;
        if (!fail_valid) begin
          fail_vec_n   = idx;
          fail_valid_n = 1'b1;
        end
      end
    end
    // Status flags are registered from the next state so they align with it.
    busy_n = (state_n == DRIVE) || (state_n == CHECK);
    done_n = (state_n == DONE);
    pass_n = done_n && (err_cnt_n == 5'd0);
  end

endmodule

// File: tb/tb_identity_checker.sv
// tb/tb_identity_checker.sv - directed bench for identity_checker with SETTLE=2
module tb_identity_checker;

  localparam int P = 3; // SETTLE + 1 cycles per vector

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [3:0] vec;
  logic [2:0] lhs, rhs;
  logic       busy, done, pass;
  logic [4:0] err_cnt;
  logic [2:0] err_mask;
  logic [3:0] fail_vec;
  logic       fail_valid;

  int mode = 0;
  int errors = 0;
  int checks = 0;

  identity_checker #(.SETTLE(2)) dut (
    .clk(clk), .rst(rst), .start(start), .vec(vec), .lhs(lhs), .rhs(rhs),
    .busy(busy), .done(done), .pass(pass), .err_cnt(err_cnt), .err_mask(err_mask),
    .fail_vec(fail_vec), .fail_valid(fail_valid)
  );

  always #5 clk = ~clk;

  // Stand-in identity block: lhs equals rhs except where the mode injects faults.
  always_comb begin
    rhs = {vec[3] ^ vec[0], vec[2], vec[1] ^ vec[0]};
    lhs = rhs;
    case (mode)
      1: if (vec == 4'd5) lhs = rhs ^ 3'b010;
      2: lhs = ~rhs;
      3: if (vec == 4'd2 || vec == 4'd6 || vec == 4'd9) lhs = rhs ^ 3'b001;
      default: lhs = rhs;
    endcase
  end

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Starts a run and walks it to cycle 49, checking busy/done/vec each cycle.
  task automatic run(input int mode_i, input bit repulse);
    int bad_busy, bad_vec;
    mode = mode_i;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("cleared_err_cnt_c1", int'(err_cnt), 0);
    chk("cleared_err_mask_c1", int'(err_mask), 0);
    chk("cleared_fail_valid_c1", int'(fail_valid), 0);
    bad_busy = 0;
    bad_vec = 0;
    for (int c = 1; c <= 16 * P; c++) begin
      if (busy !== 1'b1 || done !== 1'b0) bad_busy++;
      if (int'(vec) !== (c - 1) / P) bad_vec++;
      start = repulse && (c == 10 || c == 30);
      tick();
    end
    start = 1'b0;
    chk("busy_window_errs", bad_busy, 0);
    chk("vec_sequence_errs", bad_vec, 0);
    chk("done_c49", int'(done), 1);
    chk("busy_c49", int'(busy), 0);
    chk("vec_in_done", int'(vec), 0);
  endtask

  initial begin
    tick();
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_pass", int'(pass), 0);
    chk("rst_vec", int'(vec), 0);
    chk("rst_err_cnt", int'(err_cnt), 0);
    chk("rst_fail_valid", int'(fail_valid), 0);
    rst = 1'b0;

    run(0, 1'b0);
    chk("clean_pass", int'(pass), 1);
    chk("clean_err_cnt", int'(err_cnt), 0);
    chk("clean_err_mask", int'(err_mask), 0);
    chk("clean_fail_valid", int'(fail_valid), 0);
    repeat (5) tick();
    chk("clean_done_held", int'(done), 1);
    chk("clean_pass_held", int'(pass), 1);

    run(1, 1'b0);
    chk("v5_err_cnt", int'(err_cnt), 1);
    chk("v5_err_mask", int'(err_mask), 3'b010);
    chk("v5_fail_vec", int'(fail_vec), 5);
    chk("v5_fail_valid", int'(fail_valid), 1);
    chk("v5_pass", int'(pass), 0);

    run(2, 1'b0);
    chk("all_err_cnt", int'(err_cnt), 16);
    chk("all_err_mask", int'(err_mask), 3'b111);
    chk("all_fail_vec", int'(fail_vec), 0);
    chk("all_pass", int'(pass), 0);

    run(3, 1'b0);
    chk("three_err_cnt", int'(err_cnt), 3);
    chk("three_err_mask", int'(err_mask), 3'b001);
    chk("three_fail_vec", int'(fail_vec), 2);

    // Restart from DONE with a populated result, with ignored start pulses mid-run.
    run(0, 1'b1);
    chk("repulse_pass", int'(pass), 1);
    chk("repulse_err_cnt", int'(err_cnt), 0);

    // Asynchronous abort while vector 7 is being driven.
    mode = 2;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (21) tick();
    chk("pre_abort_vec", int'(vec), 7);
    chk("pre_abort_err_cnt", int'(err_cnt), 7);
    #2 rst = 1'b1;
    #1;
    chk("abort_vec", int'(vec), 0);
    chk("abort_busy", int'(busy), 0);
    chk("abort_err_cnt", int'(err_cnt), 0);
    chk("abort_err_mask", int'(err_mask), 0);
    chk("abort_fail_valid", int'(fail_valid), 0);
    chk("abort_done", int'(done), 0);
    #1 rst = 1'b0;
    tick();
    chk("idle_after_abort_busy", int'(busy), 0);

    run(0, 1'b0);
    chk("post_abort_pass", int'(pass), 1);
    chk("post_abort_err_cnt", int'(err_cnt), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/identity_checker.md
IDENTITY_CHECKER -- requirements
Module: identity_checker

Interface
REQ-001 SHALL have parameter SETTLE, default 2, meaning the number of cycles each vector is held before sampling; legal range 1..15.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-004 SHALL have port start, input, 1 bit: run request, sampled only in IDLE or DONE.
REQ-005 SHALL have port vec, output, 4 bits: stimulus {a,x,y,z} driven to the identity block under test.
REQ-006 SHALL have port lhs, input, 3 bits: returned left-hand sides {lhs3,lhs2,lhs1}.
REQ-007 SHALL have port rhs, input, 3 bits: returned right-hand sides {rhs3,rhs2,rhs1}.
REQ-008 SHALL have port busy, output, 1 bit: high in DRIVE and CHECK.
REQ-009 SHALL have port done, output, 1 bit: high in DONE.
REQ-010 SHALL have port pass, output, 1 bit: high in DONE when err_cnt==0.
REQ-011 SHALL have port err_cnt, output, 5 bits: count of vectors with at least one mismatching identity (0..16).
REQ-012 SHALL have port err_mask, output, 3 bits: sticky per-identity mismatch flags; bit i set when lhs[i]!=rhs[i] at any CHECK.
REQ-013 SHALL have port fail_vec, output, 4 bits: first vector that produced a mismatch.
REQ-014 SHALL have port fail_valid, output, 1 bit: fail_vec holds a captured value.

Function
REQ-015 SHALL implement FSM states IDLE, DRIVE, CHECK, DONE.
REQ-016 IDLE: start=1 -> DRIVE; in the same edge, clear idx, err_cnt, err_mask, fail_vec and fail_valid, and load the settle counter with SETTLE-1.
REQ-017 DRIVE: vec=idx; counter decrements each cycle; counter==0 -> CHECK.
REQ-018 CHECK: vec=idx; compare m=lhs^rhs combinationally; err_mask|=m; if m!=0, err_cnt+=1.
REQ-019 CHECK: if m!=0 and fail_valid==0, capture fail_vec=idx and set fail_valid=1; later mismatches do not overwrite.
REQ-020 CHECK: idx==15 -> DONE; otherwise idx+=1, reload counter with SETTLE-1 -> DRIVE.
REQ-021 idx is 4 bits and SHALL never wrap; 15 is terminal.
REQ-022 err_cnt SHALL saturate at 16; this is structurally unreachable beyond 16.
REQ-023 Timing: start-accept cycle = cycle 0; vector i is in CHECK at cycle (i+1)*(SETTLE+1); done rises at cycle 16*(SETTLE+1)+1.
REQ-024 DONE: done=1, pass=(err_cnt==0); results held indefinitely; vec=0.
REQ-025 DONE: start=1 -> restart exactly as from IDLE, clearing results in the same edge.
REQ-026 start SHALL be ignored in DRIVE and CHECK.
REQ-027 In IDLE, vec=0, busy=0, done=0 and pass=0; all outputs SHALL be registered except vec, which may decode directly from idx.

Reset
REQ-028 rst=1 SHALL immediately force state=IDLE, idx=0, counter=0, vec=0, busy=0, done=0, pass=0, err_cnt=0, err_mask=0, fail_vec=0 and fail_valid=0, independent of clk.
REQ-029 Reset asserted mid-run SHALL abort the run; no partial results are retained.
REQ-030 After rst deasserts, the first start SHALL be honoured on the first rising edge.

Verification (SETTLE=2)
REQ-031 lhs=rhs for all vectors, pulse start -> busy for cycles 1..48, done=1 and pass=1 from cycle 49, err_cnt=0, err_mask=000, fail_valid=0.
REQ-032 lhs[1] inverted only while vec==5 -> err_cnt=1, err_mask=010, fail_vec=0101, fail_valid=1, pass=0.
REQ-033 lhs=~rhs always -> err_cnt=16, err_mask=111, fail_vec=0000, pass=0.
REQ-034 start re-pulsed at cycles 10 and 30 -> ignored; done still at cycle 49 with an unchanged vec sequence 0..15.
REQ-035 rst pulsed asynchronously (between edges) while idx==7 -> all outputs 0 immediately, state IDLE; a following start runs a full 16-vector pass.
REQ-036 From DONE with err_cnt=3, start -> err_cnt, err_mask and fail_valid read 0 at cycle 1, and the run repeats.
